multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/legv8_ctrl_pkg.sv | 42 ++++
 rtl/opcode_decode.sv | 24 ++
 rtl/multicycle_control.sv | 158 +++++++++++++++
 tb/tb_multicycle_control.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - LEGv8 multicycle control constants, opcode classes and state codes
// Optional feature macro: ILLEGAL_TRAP_EN (adds the TRAP state code).
package legv8_ctrl_pkg;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
   localparam logic [5:0]  OP_B_PFX   = 6'b000101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_R,
      CLS_LDUR,
      CLS_STUR,
      CLS_CBZ,
      CLS_B
   } op_class_t;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
`ifdef ILLEGAL_TRAP_EN
   localparam logic [2:0] S_TRAP   = 3'd6;
`endif

   // Stores and CBZ read their data/test register through the Rt field.
   function automatic logic reg2loc_of(op_class_t c);
      return (c == CLS_STUR) || (c == CLS_CBZ);
   endfunction

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational LEGv8 opcode classifier
module opcode_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] Opcode,
   output op_class_t   op_class
);

   always_comb begin
      op_class = CLS_NONE;
      if ((Opcode == OP_ADD) || (Opcode == OP_SUB) ||
          (Opcode == OP_AND) || (Opcode == OP_ORR))
         op_class = CLS_R;
      else if (Opcode == OP_LDUR)
         op_class = CLS_LDUR;
      else if (Opcode == OP_STUR)
         op_class = CLS_STUR;
      else if (Opcode[10:3] == OP_CBZ_PFX)
         op_class = CLS_CBZ;
      else if (Opcode[10:5] == OP_B_PFX)
         op_class = CLS_B;
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - LEGv8 multicycle control FSM with memory wait timeout
// Optional feature macro: ILLEGAL_TRAP_EN (unclassified opcodes trap instead of NOP).
module multicycle_control
   import legv8_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Halt,
   input  logic [10:0] Opcode,
   input  logic        Zero,
   input  logic        MemReady,
   output logic        Reg2Loc,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCSrc,
   output logic [1:0]  ALUOp,
   output logic        MemErr,
   output logic        Illegal
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [2:0] state, state_nx;
   op_class_t  dec_class, cur_class;
   logic [7:0] wait_cnt;
   logic       mem_phase;
   logic       timeout;

   opcode_decode u_dec (
      .Opcode   (Opcode),
      .op_class (dec_class)
   );

   assign mem_phase = (state == S_FETCH) || (state == S_MEM);
   // Last allowed cycle without MemReady; MemReady in this cycle still completes.
   assign timeout   = mem_phase && !MemReady && (wait_cnt == WAIT_LAST);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (!Halt) state_nx = S_FETCH;
         S_FETCH: begin
            if (MemReady)     state_nx = S_DECODE;
            else if (timeout) state_nx = S_IDLE;
         end
         S_DECODE: begin
            if (dec_class == CLS_NONE)
`ifdef ILLEGAL_TRAP_EN
               state_nx = S_TRAP;
`else
               state_nx = S_IDLE;
`endif
            else
               state_nx = S_EXEC;
         end
         S_EXEC: begin
            case (cur_class)
               CLS_R:              state_nx = S_WB;
               CLS_LDUR, CLS_STUR: state_nx = S_MEM;
               default:            state_nx = S_IDLE;
            endcase
         end
         S_MEM: begin
            if (MemReady)     state_nx = (cur_class == CLS_LDUR) ? S_WB : S_IDLE;
            else if (timeout) state_nx = S_IDLE;
         end
         S_WB:     state_nx = S_IDLE;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:   state_nx = S_TRAP;
`endif
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      ALUOp    = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_EXEC: begin
            ALUSrc = (cur_class == CLS_LDUR) || (cur_class == CLS_STUR);
            if (cur_class == CLS_R)        ALUOp = ALUOP_RTYPE;
            else if (cur_class == CLS_CBZ) ALUOp = ALUOP_PASSB;
            if ((cur_class == CLS_B) || ((cur_class == CLS_CBZ) && Zero)) begin
               PCWrite = 1'b1;
               PCSrc   = 1'b1;
            end
         end
         S_MEM: begin
            MemRead  = (cur_class == CLS_LDUR);
            MemWrite = (cur_class == CLS_STUR);
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (cur_class == CLS_LDUR);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cur_class <= CLS_NONE;
         Reg2Loc   <= 1'b0;
         wait_cnt  <= 8'd0;
         MemErr    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) begin
            cur_class <= dec_class;
            Reg2Loc   <= reg2loc_of(dec_class);
         end
         if (((state_nx == S_FETCH) && (state != S_FETCH)) ||
             ((state_nx == S_MEM) && (state != S_MEM)) ||
             (state_nx == S_IDLE))
            wait_cnt <= 8'd0;
         else if (mem_phase && !MemReady)
            wait_cnt <= wait_cnt + 8'd1;
         if (timeout)
            MemErr <= 1'b1;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         illegal_q <= 1'b0;
      else if ((state == S_DECODE) && (dec_class == CLS_NONE))
         illegal_q <= 1'b1;
   end

   assign Illegal = illegal_q;
`else
   assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control (MAX_WAIT=4)
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Halt;
   logic [10:0] Opcode;
   logic        Zero;
   logic        MemReady;
   logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
   logic        IRWrite, PCWrite, PCSrc, MemErr, Illegal;
   logic [1:0]  ALUOp;

   int total = 0;
   int bad   = 0;

   multicycle_control #(.MAX_WAIT(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Halt     (Halt),
      .Opcode   (Opcode),
      .Zero     (Zero),
      .MemReady (MemReady),
      .Reg2Loc  (Reg2Loc),
      .ALUSrc   (ALUSrc),
      .MemtoReg (MemtoReg),
      .RegWrite (RegWrite),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .IRWrite  (IRWrite),
      .PCWrite  (PCWrite),
      .PCSrc    (PCSrc),
      .ALUOp    (ALUOp),
      .MemErr   (MemErr),
      .Illegal  (Illegal)
   );

   always #5 clk = ~clk;

   // {RegWrite, MemRead, MemWrite, IRWrite, PCWrite}
   wire [4:0]  strobes = {RegWrite, MemRead, MemWrite, IRWrite, PCWrite};
   wire [12:0] all_out = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                          IRWrite, PCWrite, PCSrc, ALUOp, MemErr, Illegal};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From IDLE with Halt=1: one-cycle FETCH with MemReady; returns in the DECODE cycle.
   task automatic do_fetch(input logic [10:0] op, input string tag);
      Halt     = 1'b0;
      Opcode   = op;
      MemReady = 1'b0;
      tick();
      MemReady = 1'b1;
      Halt     = 1'b1;
      #1;
      chk({tag, "_fetch_strobes"}, 16'(strobes), 16'b01011);
      chk({tag, "_fetch_pcsrc"}, 16'(PCSrc), 16'd0);
      tick();
      MemReady = 1'b0;
      #1;
      chk({tag, "_decode_strobes"}, 16'(strobes), 16'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      Halt     = 1'b1;
      Opcode   = 11'd0;
      Zero     = 1'b0;
      MemReady = 1'b0;
      #12;
      chk("reset_outputs", 16'(all_out), 16'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_halted", 16'(all_out), 16'd0);

      // ADD: FETCH(c1) DECODE(c2) EXEC(c3) WB(c4) IDLE(c5); Halt raised mid-instruction
      do_fetch(11'b10001011000, "add");
      tick();
      chk("add_exec_reg2loc", 16'(Reg2Loc), 16'd0);
      chk("add_exec_aluop", 16'(ALUOp), 16'b10);
      chk("add_exec_alusrc", 16'(ALUSrc), 16'd0);
      chk("add_exec_strobes", 16'(strobes), 16'd0);
      tick();
      chk("add_wb_strobes", 16'(strobes), 16'b10000);
      chk("add_wb_memtoreg", 16'(MemtoReg), 16'd0);
      tick();
      chk("add_idle_strobes", 16'(strobes), 16'd0);
      tick();
      chk("add_idle_held", 16'(strobes), 16'd0);

      // STUR with MemReady after 3 wait cycles (4th MEM cycle hits the timeout edge)
      do_fetch(11'b11111000000, "stur");
      tick();
      chk("stur_exec_reg2loc", 16'(Reg2Loc), 16'd1);
      chk("stur_exec_alusrc", 16'(ALUSrc), 16'd1);
      chk("stur_exec_aluop", 16'(ALUOp), 16'b00);
      for (int i = 0; i < 4; i++) begin
         tick();
         MemReady = (i == 3);
         #1;
         chk($sformatf("stur_mem%0d_strobes", i), 16'(strobes), 16'b00100);
      end
      tick();
      MemReady = 1'b0;
      #1;
      chk("stur_idle_strobes", 16'(strobes), 16'd0);
      chk("stur_no_memerr", 16'(MemErr), 16'd0);

      // CBZ taken then not taken
      do_fetch(11'b10110100101, "cbz1");
      Zero = 1'b1;
      tick();
      chk("cbz1_pc", 16'({PCWrite, PCSrc}), 16'b11);
      chk("cbz1_aluop", 16'(ALUOp), 16'b01);
      chk("cbz1_reg2loc", 16'(Reg2Loc), 16'd1);
      tick();
      chk("cbz1_idle", 16'(strobes), 16'd0);
      do_fetch(11'b10110100011, "cbz0");
      Zero = 1'b0;
      tick();
      chk("cbz0_pc", 16'({PCWrite, PCSrc}), 16'b00);
      chk("cbz0_reg2loc", 16'(Reg2Loc), 16'd1);
      chk("cbz0_strobes", 16'(strobes), 16'd0);
      tick();

      // B: unconditional PC write, Reg2Loc back to 0
      do_fetch(11'b00010110110, "b");
      tick();
      chk("b_pc", 16'({PCWrite, PCSrc}), 16'b11);
      chk("b_reg2loc", 16'(Reg2Loc), 16'd0);
      chk("b_aluop", 16'(ALUOp), 16'b00);
      tick();

      // LDUR with immediate MemReady in MEM
      do_fetch(11'b11111000010, "ldur");
      tick();
      chk("ldur_exec_alusrc", 16'(ALUSrc), 16'd1);
      chk("ldur_exec_reg2loc", 16'(Reg2Loc), 16'd0);
      tick();
      MemReady = 1'b1;
      #1;
      chk("ldur_mem_strobes", 16'(strobes), 16'b01000);
      tick();
      MemReady = 1'b0;
      #1;
      chk("ldur_wb_strobes", 16'(strobes), 16'b10000);
      chk("ldur_wb_memtoreg", 16'(MemtoReg), 16'd1);
      tick();
      chk("ldur_idle", 16'(strobes), 16'd0);

      // FETCH with MemReady on the 4th cycle: completes, no MemErr
      Halt   = 1'b0;
      Opcode = 11'b10001011000;
      tick();
      Halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("late_fetch%0d", i), 16'(strobes), 16'b01000);
         tick();
      end
      MemReady = 1'b1;
      #1;
      chk("late_fetch3_ir", 16'(strobes), 16'b01011);
      tick();
      MemReady = 1'b0;
      tick();
      tick();
      chk("late_wb", 16'(strobes), 16'b10000);
      tick();
      chk("late_no_memerr", 16'(MemErr), 16'd0);

      // FETCH timeout: MemReady never arrives
      Halt = 1'b0;
      tick();
      Halt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_fetch%0d", i), 16'(strobes), 16'b01000);
         tick();
      end
      chk("to_memerr", 16'(MemErr), 16'd1);
      chk("to_idle_strobes", 16'(strobes), 16'd0);
      tick();
      chk("to_memerr_sticky", 16'(MemErr), 16'd1);

      // Unclassified opcode 0x7FF
      do_fetch(11'h7FF, "ill");
      tick();
      Halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
`ifdef ILLEGAL_TRAP_EN
         chk($sformatf("ill_trap%0d_strobes", i), 16'(strobes), 16'd0);
         chk($sformatf("ill_trap%0d_flag", i), 16'(Illegal), 16'd1);
`else
         chk($sformatf("ill_nop%0d_flag", i), 16'(Illegal), 16'd0);
`endif
      end
`ifndef ILLEGAL_TRAP_EN
      Halt = 1'b1;
      MemReady = 1'b1;
      tick();
      MemReady = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("ill_nop_back_idle", 16'(strobes), 16'd0);
`endif
      rst_n = 1'b0;
      Halt  = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      chk("ill_after_reset", 16'(all_out), 16'd0);

      // Asynchronous reset during an LDUR MEM wait
      do_fetch(11'b11111000010, "rst");
      tick();
      tick();
      chk("rst_mem_wait", 16'(strobes), 16'b01000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", 16'(all_out), 16'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("rst_halt_idle", 16'(all_out), 16'd0);
      tick();
      chk("rst_halt_idle2", 16'(strobes), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
